// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: result width, result FIFO depth and the slave's register map.
package cordic_pkg;

  localparam int          CORDIC_DATA_W      = 32;
  localparam int          CORDIC_FIFO_DEPTH  = 8;
  localparam logic [31:0] CORDIC_RESULT_ADDR = 32'h4001_0000;
  localparam logic [31:0] CORDIC_STATUS_ADDR = 32'h4001_0004;

endpackage

// File: rtl/cordic_fifo_mem.sv
// Result storage: DEPTH x DATA_W register array, synchronous write, asynchronous read.
module cordic_fifo_mem
  import cordic_pkg::*;
#(
  parameter int DATA_W = CORDIC_DATA_W,
  parameter int DEPTH  = CORDIC_FIFO_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Array write; contents need no reset since empty masks the read port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through buffer for CORDIC result words read by the AHB-Lite slave.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter  int DATA_W = CORDIC_DATA_W,
  parameter  int DEPTH  = CORDIC_FIFO_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AW:0] ONE_C  = (AW+1)'(1);
  localparam logic [AW:0] ZERO_C = (AW+1)'(0);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              empty_s, full_s, wr_acc_s, pop_acc_s, mem_we_s;
  logic [DATA_W-1:0] mem_rdata_s;

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign wr_acc_s  = wr_en && (!full_s || rd_en);
  assign pop_acc_s = rd_en && !empty_s;
  assign mem_we_s  = wr_acc_s && !clr;

  cordic_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i   (HCLK),
    .we_i    (mem_we_s),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata_s)
  );

  // Next-state for pointers, occupancy and sticky error flags; clr wins over traffic.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = ZERO_C;
      rd_ptr_d    = ZERO_C;
      count_d     = ZERO_C;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_acc_s) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, pop_acc_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q  || (wr_en && full_s && !rd_en);
      underflow_d = underflow_q || (rd_en && empty_s);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q    <= ZERO_C;
      rd_ptr_q    <= ZERO_C;
      count_q     <= ZERO_C;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // HRDATA is driven straight from here, so an empty FIFO must read as zero.
  assign rd_data   = empty_s ? {DATA_W{1'b0}} : mem_rdata_s;
  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/cordic_result_fifo.md
# cordic_result_fifo

Result buffer between the CORDIC core output and the AHB-Lite CORDIC slave. It captures every result word the core flags valid and holds it in a first-word-fall-through queue. The bus slave pops words on data-phase reads of the result address. Occupancy, full and sticky error flags are exported for the status path and for debug.

## Interface
- DATA_W, 32, result word width
- DEPTH, 8, number of entries; power of two, minimum 2
- AW, $clog2(DEPTH), pointer index width (derived, not overridden)

- HCLK  in  1  clock, rising edge
- HRESETn  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush, one-cycle pulse
- wr_en  in  1  CORDIC result valid (valid_out_interface)
- wr_data  in  DATA_W  CORDIC result word
- rd_en  in  1  pop request from bus slave (read_fifo_en)
- rd_data  out  DATA_W  head word, fall-through (out_fifo)
- empty  out  1  no entries
- full  out  1  DEPTH entries held
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a pop arrived while empty

## Operation
- Storage: DEPTH x DATA_W array. Writes are synchronous. Reads are asynchronous at rd_ptr.
- Pointers: wr_ptr and rd_ptr are each AW+1 bits and wrap modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and MSBs differ.
- rd_data = mem[rd_ptr] when !empty, else all zeros. The slave drives HRDATA directly from rd_data, so the output must never carry a stale or X word while empty.
- Write accepted = wr_en && (!full || rd_en). A write and a pop while full both take effect and count stays DEPTH.
- Pop accepted = rd_en && !empty. On a pop while empty:
  - pointers do not move;
  - underflow is set;
  - a simultaneous write is still accepted, so count becomes 1.
- Dropped write (wr_en && full && !rd_en): the word is lost, overflow is set, and pointers and memory are unchanged.
- count: +1 on an accepted write only, -1 on an accepted pop only, unchanged when both or neither occur.
- clr takes priority over wr_en and rd_en in the same cycle. It sets pointers and count to 0, clears overflow and underflow, and leaves memory contents undefined.
- overflow and underflow stay set until clr or reset.

## Timing
- Reset values:
  - rd_data = 0
  - empty = 1
  - full = 0
  - count = 0
  - overflow = 0
  - underflow = 0
  - pointers = 0
- Write-to-visible latency is 1 cycle. A word written at edge N appears on rd_data, and empty falls, after edge N.
- A pop takes effect at the edge. The word is on rd_data during the cycle rd_en is high, and the next word (or 0) appears after the edge.
- Flags and count are registered or derived from registered pointers. There is no combinational path from wr_en or rd_en to any output.
- An asynchronous reset mid-stream empties the FIFO immediately, with no dependence on the clock.
- Back-to-back writes at 1 per cycle and back-to-back pops at 1 per cycle are sustained indefinitely with no bubbles.

## Structure
- Shared package cordic_pkg holds:
  - CORDIC_DATA_W = 32
  - CORDIC_FIFO_DEPTH = 8
  - CORDIC_RESULT_ADDR = 32'h40010000
  - CORDIC_STATUS_ADDR
- One sub-module, cordic_fifo_mem: a DEPTH x DATA_W register array with write enable, write index, and async read index. No reset on the array.
- Pointer, count and flag logic live in cordic_result_fifo.

## Test plan
- Fill and drain:
  - Write 0x11111111..0x88888888 on consecutive cycles, then assert rd_en for 8 cycles.
  - Required: count reaches 8 with full=1, rd_data returns words in write order, and the FIFO ends with empty=1 and rd_data=0.
- Overflow:
  - With the FIFO full, write 0xDEADBEEF with rd_en=0.
  - Required: overflow=1, count=8, and a full drain returns no 0xDEADBEEF.
- Underflow with simultaneous write:
  - On an empty FIFO, assert rd_en and wr_en with 0xCAFEF00D.
  - Required: underflow=1, count=1, rd_data=0xCAFEF00D on the next cycle.
- Full read+write:
  - With the FIFO full, assert wr_en (0x0000ABCD) and rd_en together.
  - Required: full stays 1, count stays 8, and 0x0000ABCD emerges last after 8 pops.
- Wrap-around:
  - Run 3*DEPTH write/pop pairs with occupancy held at 3.
  - Required: data order is preserved across pointer wrap, and count stays 3.
- clr and reset mid-operation:
  - clr with 5 entries, asserted in the same cycle as wr_en, must give count=0, empty=1, flags=0, and the concurrent write is discarded.
  - Asserting HRESETn low between clock edges must force all outputs to their reset values immediately.
